// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake/operand/result bundle for alu_seq.
//   Input side : in_valid, in_ready, op, a, b, flag_clr
//   Output side: out_valid, out_ready, result, c_flag, v_flag, z_flag, n_flag, busy
// master drives operands and out_ready. slave is the ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flag_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_flag;
  logic             v_flag;
  logic             z_flag;
  logic             n_flag;
  logic             busy;

  modport master (
    output in_valid, op, a, b, flag_clr, out_ready,
    input  in_ready, out_valid, result, c_flag, v_flag, z_flag, n_flag, busy
  );

  modport slave (
    input  in_valid, op, a, b, flag_clr, out_ready,
    output in_ready, out_valid, result, c_flag, v_flag, z_flag, n_flag, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshakes, a persistent carry for
// ADC/SBB chains, CMP, saturating shifts and an iterative shift-add unsigned multiply.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_if slave (operands in, registered result/flags out, busy)
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

  localparam logic [3:0] OpNot = 4'h0, OpSll = 4'h1, OpSrl = 4'h2, OpSra = 4'h3;
  localparam logic [3:0] OpAnd = 4'h4, OpOr  = 4'h5, OpXor = 4'h6, OpAdd = 4'h7;
  localparam logic [3:0] OpAdc = 4'h8, OpSub = 4'h9, OpSbb = 4'hA, OpCmp = 4'hB;
  localparam logic [3:0] OpMul = 4'hC;

  typedef enum logic [0:0] {StIdle = 1'b0, StMul = 1'b1} state_e;

  state_e             r_state, w_state_nxt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_c, r_v, r_z, r_n;
  logic               r_carry;
  logic [2*WIDTH-1:0] r_mcand, r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [SHW-1:0]     r_cnt;

  logic               w_in_ready, w_accept, w_cin, w_load;
  logic [WIDTH:0]     w_sum, w_diff, w_sll, w_srl, w_sra;
  logic [WIDTH-1:0]   w_alu_res, w_zn_src, w_ld_res;
  logic               w_alu_c, w_alu_v;
  logic               w_ld_c, w_ld_v, w_ld_z, w_ld_n;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_in_ready = (r_state == StIdle) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_cin      = bus.flag_clr ? 1'b0 : r_carry;

  // One extra bit on each side captures carry/borrow and the last bit shifted out.
  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b}
                + {{WIDTH{1'b0}}, (bus.op == OpAdc) && w_cin};
  assign w_diff = {1'b0, bus.a} - {1'b0, bus.b}
                - {{WIDTH{1'b0}}, (bus.op == OpSbb) && w_cin};
  assign w_sll  = {1'b0, bus.a} << bus.b;
  assign w_srl  = {bus.a, 1'b0} >> bus.b;
  assign w_sra  = $signed({bus.a, 1'b0}) >>> bus.b;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (bus.op)
      OpNot: w_alu_res = ~bus.a;
      OpSll: begin
        w_alu_res = w_sll[WIDTH-1:0];
        w_alu_c   = w_sll[WIDTH];
      end
      OpSrl: begin
        w_alu_res = w_srl[WIDTH:1];
        w_alu_c   = w_srl[0];
      end
      OpSra: begin
        w_alu_res = w_sra[WIDTH:1];
        w_alu_c   = w_sra[0];
      end
      OpAnd: w_alu_res = bus.a & bus.b;
      OpOr:  w_alu_res = bus.a | bus.b;
      OpXor: w_alu_res = bus.a ^ bus.b;
      OpAdd, OpAdc: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpSub, OpSbb, OpCmp: begin
        w_alu_res = (bus.op == OpCmp) ? bus.a : w_diff[WIDTH-1:0];
        w_alu_c   = w_diff[WIDTH];
        w_alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      default: ;
    endcase
    // CMP passes a through but reports Z/N of the difference.
    w_zn_src = (bus.op == OpCmp) ? w_diff[WIDTH-1:0] : w_alu_res;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ld_res    = w_alu_res;
    w_ld_c      = w_alu_c;
    w_ld_v      = w_alu_v;
    w_ld_z      = (w_zn_src == '0);
    w_ld_n      = w_zn_src[WIDTH-1];
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (bus.op == OpMul) w_state_nxt = StMul;
          else                 w_load      = 1'b1;
        end
      end
      StMul: begin
        if (r_cnt == CntLast) begin
          w_load      = 1'b1;
          w_ld_res    = w_acc_nxt[WIDTH-1:0];
          w_ld_c      = |w_acc_nxt[2*WIDTH-1:WIDTH];
          w_ld_v      = |w_acc_nxt[2*WIDTH-1:WIDTH];
          w_ld_z      = (w_acc_nxt[WIDTH-1:0] == '0);
          w_ld_n      = w_acc_nxt[WIDTH-1];
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_carry     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_load || (r_out_valid && !bus.out_ready);
      // A completing op's carry takes priority over a simultaneous flag_clr.
      r_carry     <= w_load ? w_ld_c : (bus.flag_clr ? 1'b0 : r_carry);
      if (w_load) begin
        r_result <= w_ld_res;
        r_c      <= w_ld_c;
        r_v      <= w_ld_v;
        r_z      <= w_ld_z;
        r_n      <= w_ld_n;
      end
    end
  end

  // Shift-add multiplier: one multiplier bit per cycle while in StMul.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if ((r_state == StIdle) && w_accept && (bus.op == OpMul)) begin
      r_mcand  <= {{WIDTH{1'b0}}, bus.a};
      r_mplier <= bus.b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == StMul) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_acc_nxt;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.c_flag    = r_c;
  assign bus.v_flag    = r_v;
  assign bus.z_flag    = r_z;
  assign bus.n_flag    = r_n;
  assign bus.busy      = (r_state == StMul);
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=8). Directed cases push literal
// expectations; random cases push values from an integer reference model. A separate
// monitor pops and compares on every output transfer.
module tb_alu_seq;
  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } exp_t;

  logic clk;
  logic rst_n;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   m_carry  = 1'b0;
  bit   bp_en    = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input bit c, input bit v, input bit z,
                              input bit n);
    exp_t e;
    e.res = r; e.c = c; e.v = v; e.z = z; e.n = n;
    return e;
  endfunction

  // Reference model in plain integer arithmetic; shifts move one bit at a time.
  function automatic exp_t model(input logic [3:0] op, input int a, input int b, input bit cin);
    int   mask;
    int   half;
    int   sa;
    int   sb;
    int   r;
    int   s;
    int   z_src;
    bit   c;
    bit   v;
    bit   ci;
    exp_t e;
    mask = (1 << W) - 1;
    half = 1 << (W - 1);
    sa   = (a >= half) ? a - (1 << W) : a;
    sb   = (b >= half) ? b - (1 << W) : b;
    r    = 0;
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      4'h0: r = ~a & mask;
      4'h1: begin
        r = a;
        for (int i = 0; i < b; i++) begin c = ((r >> (W - 1)) & 1) != 0; r = (r << 1) & mask; end
      end
      4'h2: begin
        r = a;
        for (int i = 0; i < b; i++) begin c = (r & 1) != 0; r = r >> 1; end
      end
      4'h3: begin
        r = a;
        for (int i = 0; i < b; i++) begin c = (r & 1) != 0; r = (r >> 1) | (r & half); end
      end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7, 4'h8: begin
        ci = (op == 4'h8) && cin;
        s  = a + b + int'(ci);
        r  = s & mask;
        c  = s > mask;
        s  = sa + sb + int'(ci);
        v  = (s >= half) || (s < -half);
      end
      4'h9, 4'hA, 4'hB: begin
        ci = (op == 4'hA) && cin;
        s  = a - b - int'(ci);
        r  = s & mask;
        c  = s < 0;
        s  = sa - sb - int'(ci);
        v  = (s >= half) || (s < -half);
      end
      4'hC: begin
        s = a * b;
        r = s & mask;
        c = (s >> W) != 0;
        v = c;
      end
      default: r = 0;
    endcase
    z_src = r;
    if (op == 4'hB) r = a;
    e.res = r[W-1:0];
    e.c   = c;
    e.v   = v;
    e.z   = (z_src == 0);
    e.n   = ((z_src >> (W - 1)) & 1) != 0;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit fc, input bit push, input bit lit_en, input exp_t lit,
                       output int waited);
    exp_t e;
    bit   accepted;
    waited       = 0;
    accepted     = 1'b0;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.flag_clr = fc;
    while (!accepted && waited < 100) begin
      if (bp_en) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1'b1;
        e        = model(op, int'(a), int'(b), fc ? 1'b0 : m_carry);
        m_carry  = e.c;
        if (push) sb_q.push_back(lit_en ? lit : e);
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) check("accept_timeout", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b0;
    bus.flag_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.in_valid = 1'b0;
      if (bp_en) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
  endtask

  // Directed single-cycle op with a literal expectation and a latency-1 check.
  task automatic dir(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input bit fc, input exp_t lit);
    int waited;
    issue(op, a, b, fc, 1'b1, 1'b1, lit, waited);
    check("latency1_out_valid", 32'(bus.out_valid), 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_output", 32'(bus.out_valid), 0);
        end else begin
          e = sb_q.pop_front();
          check("sb_result_flags",
                32'({bus.result, bus.c_flag, bus.v_flag, bus.z_flag, bus.n_flag}), 32'(e));
        end
      end
    end
  end

  initial begin : main
    int          waited;
    int          seen;
    logic [3:0]  r_op;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    bit          r_fc;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 4'h0;
    bus.a         = '0;
    bus.b         = '0;
    bus.flag_clr  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_result_flags",
          32'({bus.result, bus.c_flag, bus.v_flag, bus.z_flag, bus.n_flag}), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);

    // Arithmetic and carry chaining
    dir(4'h7, 8'h7F, 8'h01, 1'b0, mk(8'h80, 1'b0, 1'b1, 1'b0, 1'b1));
    dir(4'h7, 8'hFF, 8'h01, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
    dir(4'h8, 8'h00, 8'h00, 1'b0, mk(8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
    dir(4'h7, 8'hFF, 8'h01, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
    dir(4'h8, 8'h00, 8'h00, 1'b1, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    dir(4'h9, 8'h00, 8'h01, 1'b0, mk(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1));
    dir(4'hA, 8'h05, 8'h02, 1'b0, mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0));
    dir(4'h9, 8'h80, 8'h01, 1'b0, mk(8'h7F, 1'b0, 1'b1, 1'b0, 1'b0));
    // Shifts, including saturating amounts
    dir(4'h1, 8'h81, 8'h01, 1'b0, mk(8'h02, 1'b1, 1'b0, 1'b0, 1'b0));
    dir(4'h2, 8'h81, 8'h08, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
    dir(4'h3, 8'h80, 8'h03, 1'b0, mk(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1));
    dir(4'h3, 8'h80, 8'h09, 1'b0, mk(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1));
    dir(4'h2, 8'h81, 8'h00, 1'b0, mk(8'h81, 1'b0, 1'b0, 1'b0, 1'b1));
    dir(4'h1, 8'h81, 8'h0A, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    dir(4'hD, 8'h12, 8'h34, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));

    // Multiply timing: busy and in_ready low for W cycles, result at accept+W
    issue(4'hC, 8'h10, 8'h10, 1'b0, 1'b1, 1'b1, mk(8'h00, 1'b1, 1'b1, 1'b1, 1'b0), waited);
    for (int i = 0; i < int'(W); i++) begin
      check("mul_busy_inready_outvalid", 32'({bus.busy, bus.in_ready, bus.out_valid}), 32'h4);
      @(posedge clk);
      #1;
    end
    check("mul_done_outvalid_busy", 32'({bus.out_valid, bus.busy}), 32'h2);

    // Reset during a multiply aborts it
    issue(4'hC, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0), waited);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    sb_q.delete();
    m_carry = 1'b0;
    #1;
    check("midmul_reset_outputs",
          32'({bus.result, bus.c_flag, bus.v_flag, bus.z_flag, bus.n_flag,
               bus.out_valid, bus.busy}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen  = 0;
    repeat (12) begin
      if (bus.out_valid || bus.busy) seen++;
      @(posedge clk);
      #1;
    end
    check("midmul_no_output_after_reset", 32'(seen), 0);

    // Backpressure: CMP result held, in_ready low, then release with back-to-back ops
    bus.out_ready = 1'b0;
    dir(4'hB, 8'h05, 8'h05, 1'b0, mk(8'h05, 1'b0, 1'b0, 1'b1, 1'b0));
    repeat (3) begin
      check("bp_hold", 32'({bus.result, bus.c_flag, bus.v_flag, bus.z_flag, bus.n_flag,
                             bus.out_valid, bus.in_ready}), 32'({8'h05, 4'b0010, 2'b10}));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    issue(4'h7, 8'h03, 8'h04, 1'b0, 1'b1, 1'b1, mk(8'h07, 1'b0, 1'b0, 1'b0, 1'b0), waited);
    check("bp_release_same_edge", 32'(waited), 0);
    issue(4'h6, 8'hF0, 8'h0F, 1'b0, 1'b1, 1'b1, mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1), waited);
    check("throughput_2", 32'(waited), 0);
    issue(4'h9, 8'h10, 8'h10, 1'b0, 1'b1, 1'b1, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0), waited);
    check("throughput_3", 32'(waited), 0);
    check("throughput_out_valid", 32'(bus.out_valid), 1);

    // Randomized traffic with random backpressure against the reference model
    bp_en = 1'b1;
    repeat (400) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = W'($urandom);
      r_b  = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 10)) : W'($urandom);
      r_fc = ($urandom_range(0, 3) == 0);
      issue(r_op, r_a, r_b, r_fc, 1'b1, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0), waited);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    bp_en         = 1'b0;
    bus.out_ready = 1'b1;
    seen          = 0;
    while (sb_q.size() != 0 && seen < 50) begin
      seen++;
      @(posedge clk);
      #1;
    end
    check("drain_scoreboard_empty", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU with a valid/ready handshake on input and output. It generalises the 4-bit combinational datapath ALU to WIDTH bits and adds a persistent carry flag for multi-word ADC/SBB chains, a CMP operation, saturating shift semantics and an iterative multi-cycle unsigned multiply. It sits between the operand/decode stage and the writeback stage of the datapath.

## Interface

- WIDTH, 8, operand/result width in bits; legal range 4..32.
- SHW, $clog2(WIDTH), derived local parameter; not overridable.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  op/a/b are valid.
- in_ready  out  1  block accepts an op this cycle.
- op  in  4  opcode.
- a, b  in  WIDTH  operands.
- flag_clr  in  1  clears the stored carry flag.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- c_flag, v_flag, z_flag, n_flag  out  1 each  registered carry/borrow, signed overflow, zero, negative.
- busy  out  1  multiply in progress.

## Operation

- Opcodes: 0000 NOT a; 0001 SLL; 0010 SRL; 0011 SRA; 0100 AND; 0101 OR; 0110 XOR; 0111 ADD; 1000 ADC; 1001 SUB; 1010 SBB; 1011 CMP; 1100 MUL; 1101–1111 reserved.
- Effective carry-in: cin = flag_clr ? 0 : c_flag.
- ADD/ADC: {C,r} = a + b + (ADC ? cin : 0). V = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
- SUB/SBB: r = a − b − (SBB ? cin : 0). C = 1 when a borrow occurs, i.e. unsigned a < b + borrow-in. V = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
- CMP: flags computed exactly as SUB. The result bus carries a unchanged. Z and N come from the difference.
- Shifts: b is an unsigned amount over its full width.
  - b=0: result = a, C=0.
  - 1≤b≤WIDTH: C = last bit shifted out.
  - b≥WIDTH: SLL/SRL result 0; SRA result is all copies of a[msb].
  - b>WIDTH: C=0 for SLL/SRL; C=a[msb] for SRA.
  - All shifts: V=0.
- NOT/AND/OR/XOR: C=0, V=0.
- MUL: unsigned a×b computed shift-add, one multiplier bit per cycle. result = low WIDTH bits; C = V = (high WIDTH bits ≠ 0).
- Reserved opcodes: result 0, C=0, V=0, Z=1, N=0.
- Z = (r == 0) and N = r[msb] for every op except CMP and reserved.
- Stored c_flag loads the new C in the same edge the result loads. If that edge also has flag_clr, the op's C wins. flag_clr with no completing op clears c_flag.
- FSM:
  - IDLE: a non-MUL op is completed on its acceptance edge. An accepted MUL goes to MUL.
  - MUL: runs WIDTH iterations, loads the result on the last one, then returns to IDLE.
  - busy = (state == MUL).
- in_ready = (state == IDLE) && (!out_valid || out_ready).

## Timing

- Reset (asynchronous, immediate):
  - state IDLE; out_valid=0; result=0; all flags 0; stored carry 0.
  - in_ready=1 from the first cycle after deassertion.
- Accept = in_valid && in_ready at a rising edge.
- Single-cycle ops: accepted at edge k → out_valid=1 and result/flags valid after edge k (latency 1). Back-to-back throughput is 1/cycle while out_ready=1.
- MUL: accepted at edge k → in_ready=0 and busy=1 from edge k through edge k+WIDTH−1. Result loads at edge k+WIDTH (latency WIDTH). busy deasserts after edge k+WIDTH.
- Output handshake: result and flags are held stable while out_valid && !out_ready. out_valid clears on an out_ready edge unless a new result loads on that same edge.
- A chained ADC/SBB accepted on the edge right after the previous completion sees that op's carry.
- Reset mid-MUL aborts the multiply; no output is produced.
- Inputs are ignored while in_ready=0.

## Test plan

- WIDTH=8. ADD 0x7F+0x01 → result 0x80, V=1, N=1, C=0, Z=0, out_valid one cycle after accept.
- ADD 0xFF+0x01 → 0x00, C=1, Z=1. Next cycle ADC 0x00+0x00 → 0x01, C=0. Repeat the pair with flag_clr=1 on the ADC → 0x00, Z=1.
- SUB 0x00−0x01 → 0xFF, C=1, N=1, V=0. Then SBB 0x05−0x02 → 0x02. SUB 0x80−0x01 → 0x7F, V=1.
- Shifts:
  - SLL 0x81 by 1 → 0x02, C=1.
  - SRL 0x81 by 8 → 0x00, C=1.
  - SRA 0x80 by 3 → 0xF0, C=0.
  - SRA 0x80 by 9 → 0xFF, C=1.
  - SRL 0x81 by 0 → 0x81, C=0.
- MUL 0x10×0x10 → result 0x00, C=V=1, Z=1. Check in_ready=0 and busy=1 for 8 cycles, out_valid at accept+8. Repeat with rst_n pulsed low 4 cycles in → no out_valid, all outputs 0.
- Backpressure: hold out_ready=0 after CMP 0x05 vs 0x05 → result 0x05, Z=1, C=0 held stable, in_ready=0. Release out_ready → next op accepted on the same edge, throughput 1/cycle.
